linked_list_searcher: RTL and testbench
=======================================

Name: linked_list_searcher

Overview:
- Parametrised linked-list search engine with an internal node store, a host write port and a valid/ready search request.
- Walks the list from a given head, one hop per cycle, matching either the node address or the node data against a key.
- Reports hit/miss, the matching address, hop count, and a timeout flag for cyclic or over-long lists.
- Sits beside the memory-management/lookup logic as the general-purpose list walker.

Parameters:
- ADDR_WIDTH, 4: node address width; store depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: payload width per node.
- MAX_HOPS, 2**ADDR_WIDTH: hop budget before timeout; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  node write strobe.
- wr_addr  in  ADDR_WIDTH  node written.
- wr_data  in  DATA_WIDTH  payload written.
- wr_next  in  ADDR_WIDTH  next pointer written; all-ones = NULL.
- start_valid  in  1  search request.
- start_ready  out  1  high in IDLE only.
- start_node  in  ADDR_WIDTH  list head.
- key  in  max(ADDR_WIDTH,DATA_WIDTH)  search key, LSB-aligned.
- mode  in  1  0 = match node address, 1 = match node data.
- done  out  1  one-cycle result strobe.
- found  out  1  hit; valid while done.
- found_addr  out  ADDR_WIDTH  matching node; 0 on miss.
- hop_count  out  clog2(MAX_HOPS+1)  hops taken before termination.
- timeout  out  1  hop budget exhausted without hit or NULL.

Behaviour:
- Store: 2**ADDR_WIDTH entries of {data, next}. Contents are not reset. Write is synchronous; read is combinational.
- Write/walk collision: a write in the same cycle a node is being evaluated is seen from the next cycle only, i.e. the walk reads the old value.
- NULL_ADDR = all-ones. A node at address NULL_ADDR is searchable as a head but can never be reached as a successor.
- FSM states: IDLE, WALK, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready, latch start_node→curr, key, mode; hops←0; go to WALK.
- WALK, each cycle evaluates curr:
  - match (mode 0: curr==key[ADDR_WIDTH-1:0]; mode 1: data[curr]==key[DATA_WIDTH-1:0]) → found=1, found_addr=curr.
  - else next[curr]==NULL → found=0.
  - else hops==MAX_HOPS-1 → found=0, timeout=1.
  - else curr←next[curr], hops←hops+1, stay in WALK.
  - Termination priority: match > NULL > timeout.
  - On termination, register the results and go to DONE.
- DONE: done=1 for exactly one cycle; results held stable until the next done; then go to IDLE.
- Latency: match at hop k gives done high k+2 cycles after the handshake edge, with hop_count=k.
- start_valid outside IDLE is ignored; the requester must hold it until ready.
- Reset (any state, including mid-walk): state=IDLE, done=0, found=0, found_addr=0, hop_count=0, timeout=0. start_ready=1 the cycle after reset deasserts. Store contents are kept.
- Unused key MSBs are ignored.

Optional Feature:
- LL_STATS_EN defined: adds outputs stat_searches[15:0] and stat_hits[15:0].
  - Both increment on each done (hits only when found=1).
  - Saturate at 16'hFFFF; reset to 0.
- LL_STATS_EN undefined: the ports and counters are absent; otherwise identical behaviour.

Decomposition:
- Package ll_pkg:
  - state enum ll_state_e {IDLE, WALK, DONE};
  - match-mode enum {MATCH_ADDR, MATCH_DATA};
  - function giving NULL_ADDR for a width.
- Sub-module ll_node_store: array, write port, combinational read port. Instantiated once.

Test Plan:
- List 3→7→2→NULL, mode 0, key=2, start=3 → found=1, found_addr=2, hop_count=2, done 4 cycles after handshake.
- Same list, mode 1, data[7]=0xA5, key=0xA5 → found=1, found_addr=7, hop_count=1.
- Same list, key=9 → found=0, timeout=0, hop_count=2, found_addr=0.
- Cycle 1→4→1, MAX_HOPS=16, key=5 → timeout=1, found=0, hop_count=15.
- Head 5 with next[5]=NULL, key=5, mode 0 → found=1, hop_count=0, done 2 cycles after handshake; then rst low mid-walk on a long list → done never pulses, outputs 0, start_ready=1 the cycle after release.
- With LL_STATS_EN: 3 searches, 2 hits → stat_searches=3, stat_hits=2; force saturation → counter holds at 0xFFFF.

Source files
------------

// File: rtl/ll_pkg.sv
// Package for the linked-list searcher.
// Provides:
//   ll_state_e - walker FSM states (IDLE, WALK, DONE)
//   ll_mode_e  - match selection (MATCH_ADDR compares node address, MATCH_DATA compares payload)
//   null_addr  - all-ones NULL pointer value for a given address width
package ll_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      DONE
   } ll_state_e;

   typedef enum logic {
      MATCH_ADDR,
      MATCH_DATA
   } ll_mode_e;

   // NULL pointer is all ones; returned as an int so callers can cast to their own width.
   function automatic int unsigned null_addr(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/ll_node_store.sv
// Node store for the linked-list searcher: 2**ADDR_WIDTH entries of {data, next}.
// Contents are not reset. Write is synchronous; read is combinational, so a node
// written in the same cycle it is read returns its old value until the next cycle.
// Ports:
//   clk        - clock
//   wr_en_i    - write strobe
//   wr_addr_i  - entry written
//   wr_data_i  - payload written
//   wr_next_i  - next pointer written
//   rd_addr_i  - entry read
//   rd_data_o  - payload of rd_addr_i
//   rd_next_o  - next pointer of rd_addr_i
module ll_node_store #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] wr_next_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [ADDR_WIDTH-1:0] rd_next_o
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] data_q [Depth];
   logic [ADDR_WIDTH-1:0] next_q [Depth];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         data_q[wr_addr_i] <= wr_data_i;
         next_q[wr_addr_i] <= wr_next_i;
      end
   end

   always_comb begin
      rd_data_o = data_q[rd_addr_i];
      rd_next_o = next_q[rd_addr_i];
   end

endmodule

// File: rtl/linked_list_searcher.sv
// Linked-list search engine. Walks a list held in an internal node store from a
// given head, one hop per cycle, matching either the node address or the node
// payload against a key. Reports hit/miss, matching address, hop count and a
// timeout for cyclic or over-long lists.
// Optional feature: define LL_STATS_EN to add saturating search/hit counters.
// Ports:
//   clk, rst            - clock; synchronous active-low reset
//   wr_en_i/wr_addr_i/wr_data_i/wr_next_i - host node write port (next all-ones = NULL)
//   start_valid_i/start_ready_o - search request handshake (ready only in IDLE)
//   start_node_i        - list head
//   key_i               - search key, LSB-aligned
//   mode_i              - 0 = match address, 1 = match data
//   done_o              - one-cycle result strobe
//   found_o             - hit
//   found_addr_o        - matching node, 0 on miss
//   hop_count_o         - hops taken before termination
//   timeout_o           - hop budget exhausted
//   stat_searches_o/stat_hits_o - (LL_STATS_EN only) saturating counters
module linked_list_searcher
   import ll_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_HOPS   = 2 ** ADDR_WIDTH,
   localparam int unsigned KeyWidth  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
   localparam int unsigned HopWidth  = $clog2(MAX_HOPS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] wr_next_i,
   input  logic                  start_valid_i,
   output logic                  start_ready_o,
   input  logic [ADDR_WIDTH-1:0] start_node_i,
   input  logic [KeyWidth-1:0]   key_i,
   input  logic                  mode_i,
   output logic                  done_o,
   output logic                  found_o,
   output logic [ADDR_WIDTH-1:0] found_addr_o,
   output logic [HopWidth-1:0]   hop_count_o,
`ifdef LL_STATS_EN
   output logic [15:0]           stat_searches_o,
   output logic [15:0]           stat_hits_o,
`endif
   output logic                  timeout_o
);

   localparam logic [ADDR_WIDTH-1:0] NullAddr = ADDR_WIDTH'(null_addr(ADDR_WIDTH));
   localparam logic [HopWidth-1:0]   LastHop  = HopWidth'(MAX_HOPS - 1);

   ll_state_e             state_q;
   logic [ADDR_WIDTH-1:0] curr_q;
   logic [KeyWidth-1:0]   key_q;
   ll_mode_e              mode_q;
   logic [HopWidth-1:0]   hops_q;
   // Termination kind, published to the outputs in DONE.
   logic                  hit_q;
   logic                  tmo_q;

   logic                  done_q;
   logic                  found_q;
   logic [ADDR_WIDTH-1:0] found_addr_q;
   logic [HopWidth-1:0]   hop_count_q;
   logic                  timeout_q;

   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] rd_next;
   logic                  match;
   logic                  is_null;
   logic                  last_hop;

   ll_node_store #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_store (
      .clk       (clk),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .wr_next_i (wr_next_i),
      .rd_addr_i (curr_q),
      .rd_data_o (rd_data),
      .rd_next_o (rd_next)
   );

   always_comb begin
      match = 1'b0;
      if (mode_q == MATCH_ADDR) begin
         match = (curr_q == key_q[ADDR_WIDTH-1:0]);
      end else begin
         match = (rd_data == key_q[DATA_WIDTH-1:0]);
      end
      is_null  = (rd_next == NullAddr);
      last_hop = (hops_q == LastHop);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         curr_q       <= '0;
         key_q        <= '0;
         mode_q       <= MATCH_ADDR;
         hops_q       <= '0;
         hit_q        <= 1'b0;
         tmo_q        <= 1'b0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         found_addr_q <= '0;
         hop_count_q  <= '0;
         timeout_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_valid_i) begin
                  curr_q  <= start_node_i;
                  key_q   <= key_i;
                  mode_q  <= ll_mode_e'(mode_i);
                  hops_q  <= '0;
                  state_q <= WALK;
               end
            end
            WALK: begin
               // Priority: match > NULL > timeout. curr_q/hops_q are frozen on termination.
               if (match) begin
                  hit_q   <= 1'b1;
                  tmo_q   <= 1'b0;
                  state_q <= DONE;
               end else if (is_null) begin
                  hit_q   <= 1'b0;
                  tmo_q   <= 1'b0;
                  state_q <= DONE;
               end else if (last_hop) begin
                  hit_q   <= 1'b0;
                  tmo_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  curr_q <= rd_next;
                  hops_q <= hops_q + HopWidth'(1);
               end
            end
            DONE: begin
               // Results and strobe change together so they stay stable until the next done.
               done_q       <= 1'b1;
               found_q      <= hit_q;
               found_addr_q <= hit_q ? curr_q : '0;
               hop_count_q  <= hops_q;
               timeout_q    <= tmo_q;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign start_ready_o = (state_q == IDLE);
   assign done_o        = done_q;
   assign found_o       = found_q;
   assign found_addr_o  = found_addr_q;
   assign hop_count_o   = hop_count_q;
   assign timeout_o     = timeout_q;

`ifdef LL_STATS_EN
   logic [15:0] stat_searches_q;
   logic [15:0] stat_hits_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_searches_q <= '0;
         stat_hits_q     <= '0;
      end else if (state_q == DONE) begin
         if (stat_searches_q != 16'hFFFF) begin
            stat_searches_q <= stat_searches_q + 16'd1;
         end
         if (hit_q && (stat_hits_q != 16'hFFFF)) begin
            stat_hits_q <= stat_hits_q + 16'd1;
         end
      end
   end

   assign stat_searches_o = stat_searches_q;
   assign stat_hits_o     = stat_hits_q;
`endif

endmodule

// File: tb/tb_linked_list_searcher.sv
// Directed bench for linked_list_searcher (ADDR_WIDTH=4, DATA_WIDTH=8, MAX_HOPS=16).
module tb_linked_list_searcher;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] wr_next;
   logic       start_valid;
   logic       start_ready;
   logic [3:0] start_node;
   logic [7:0] key;
   logic       mode;
   logic       done;
   logic       found;
   logic [3:0] found_addr;
   logic [4:0] hop_count;
   logic       timeout;
`ifdef LL_STATS_EN
   logic [15:0] stat_searches;
   logic [15:0] stat_hits;
`endif

   int checks;
   int passes;

   linked_list_searcher #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (8),
      .MAX_HOPS   (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en_i       (wr_en),
      .wr_addr_i     (wr_addr),
      .wr_data_i     (wr_data),
      .wr_next_i     (wr_next),
      .start_valid_i (start_valid),
      .start_ready_o (start_ready),
      .start_node_i  (start_node),
      .key_i         (key),
      .mode_i        (mode),
      .done_o        (done),
      .found_o       (found),
      .found_addr_o  (found_addr),
      .hop_count_o   (hop_count),
`ifdef LL_STATS_EN
      .stat_searches_o (stat_searches),
      .stat_hits_o     (stat_hits),
`endif
      .timeout_o     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_node(input logic [3:0] a, input logic [7:0] d, input logic [3:0] n);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_next = n;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Issues one request and returns the number of edges from the handshake edge
   // to the edge after which done is seen high (-1 if it never rises).
   task automatic run_search(input logic [3:0] head, input logic [7:0] k, input logic m,
                             output int lat);
      @(negedge clk);
      start_valid = 1'b1;
      start_node  = head;
      key         = k;
      mode        = m;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 64; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
      checks++; if (found !== 1'b0) $display("FAIL reset_found got %b want 0", found); else passes++;
      checks++; if (found_addr !== 4'd0) $display("FAIL reset_addr got %0d want 0", found_addr);
      else passes++;
      checks++; if (hop_count !== 5'd0) $display("FAIL reset_hops got %0d want 0", hop_count);
      else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout);
      else passes++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (start_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", start_ready);
      else passes++;
   endtask

   task automatic load_lists();
      for (int i = 0; i < 16; i++) write_node(4'(i), 8'(8'h10 + i), 4'hF);
      write_node(4'd3, 8'h33, 4'd7);
      write_node(4'd7, 8'hA5, 4'd2);
      write_node(4'd2, 8'h22, 4'hF);
      write_node(4'd1, 8'h11, 4'd4);
      write_node(4'd4, 8'h44, 4'd1);
   endtask

   task automatic test_addr_match();
      int lat;
      run_search(4'd3, 8'd2, 1'b0, lat);
      checks++; if (lat !== 4) $display("FAIL addr_latency got %0d want 4", lat); else passes++;
      checks++; if (found !== 1'b1) $display("FAIL addr_found got %b want 1", found); else passes++;
      checks++; if (found_addr !== 4'd2) $display("FAIL addr_addr got %0d want 2", found_addr);
      else passes++;
      checks++; if (hop_count !== 5'd2) $display("FAIL addr_hops got %0d want 2", hop_count);
      else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL addr_timeout got %b want 0", timeout);
      else passes++;
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) $display("FAIL addr_done_width got %b want 0", done); else passes++;
   endtask

   task automatic test_data_match();
      int lat;
      run_search(4'd3, 8'hA5, 1'b1, lat);
      checks++; if (lat !== 3) $display("FAIL data_latency got %0d want 3", lat); else passes++;
      checks++; if (found !== 1'b1) $display("FAIL data_found got %b want 1", found); else passes++;
      checks++; if (found_addr !== 4'd7) $display("FAIL data_addr got %0d want 7", found_addr);
      else passes++;
      checks++; if (hop_count !== 5'd1) $display("FAIL data_hops got %0d want 1", hop_count);
      else passes++;
   endtask

   task automatic test_miss();
      int lat;
      run_search(4'd3, 8'd9, 1'b0, lat);
      checks++; if (lat !== 4) $display("FAIL miss_latency got %0d want 4", lat); else passes++;
      checks++; if (found !== 1'b0) $display("FAIL miss_found got %b want 0", found); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL miss_timeout got %b want 0", timeout);
      else passes++;
      checks++; if (hop_count !== 5'd2) $display("FAIL miss_hops got %0d want 2", hop_count);
      else passes++;
      checks++; if (found_addr !== 4'd0) $display("FAIL miss_addr got %0d want 0", found_addr);
      else passes++;
   endtask

   task automatic test_timeout();
      int lat;
      run_search(4'd1, 8'd5, 1'b0, lat);
      checks++; if (lat !== 17) $display("FAIL tmo_latency got %0d want 17", lat); else passes++;
      checks++; if (timeout !== 1'b1) $display("FAIL tmo_timeout got %b want 1", timeout);
      else passes++;
      checks++; if (found !== 1'b0) $display("FAIL tmo_found got %b want 0", found); else passes++;
      checks++; if (hop_count !== 5'd15) $display("FAIL tmo_hops got %0d want 15", hop_count);
      else passes++;
   endtask

   task automatic test_head_null();
      int lat;
      run_search(4'd5, 8'd5, 1'b0, lat);
      checks++; if (lat !== 2) $display("FAIL head_latency got %0d want 2", lat); else passes++;
      checks++; if (found !== 1'b1) $display("FAIL head_found got %b want 1", found); else passes++;
      checks++; if (found_addr !== 4'd5) $display("FAIL head_addr got %0d want 5", found_addr);
      else passes++;
      checks++; if (hop_count !== 5'd0) $display("FAIL head_hops got %0d want 0", hop_count);
      else passes++;
   endtask

   task automatic test_reset_mid_walk();
      bit seen_done;
      @(negedge clk);
      start_valid = 1'b1;
      start_node  = 4'd1;
      key         = 8'd5;
      mode        = 1'b0;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (found !== 1'b0) $display("FAIL rstw_found got %b want 0", found); else passes++;
      checks++; if (found_addr !== 4'd0) $display("FAIL rstw_addr got %0d want 0", found_addr);
      else passes++;
      checks++; if (done !== 1'b0) $display("FAIL rstw_done got %b want 0", done); else passes++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (start_ready !== 1'b1) $display("FAIL rstw_ready got %b want 1", start_ready);
      else passes++;
      seen_done = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      checks++; if (seen_done !== 1'b0) $display("FAIL rstw_no_done got %b want 0", seen_done);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int lat;
      // Upper key nibble must be ignored in address mode.
      run_search(4'd3, 8'hF2, 1'b0, lat);
      checks++; if (found_addr !== 4'd2) $display("FAIL b2b_msb_addr got %0d want 2", found_addr);
      else passes++;
      run_search(4'd7, 8'h22, 1'b1, lat);
      checks++; if (lat !== 3) $display("FAIL b2b_latency got %0d want 3", lat); else passes++;
      checks++; if (found_addr !== 4'd2) $display("FAIL b2b_addr got %0d want 2", found_addr);
      else passes++;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (hop_count !== 5'd1) $display("FAIL b2b_hold_hops got %0d want 1", hop_count);
      else passes++;
   endtask

`ifdef LL_STATS_EN
   task automatic test_stats();
      int lat;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_search(4'd3, 8'd2, 1'b0, lat);
      run_search(4'd3, 8'd9, 1'b0, lat);
      run_search(4'd5, 8'd5, 1'b0, lat);
      @(posedge clk);
      #1;
      checks++; if (stat_searches !== 16'd3) $display("FAIL stat_searches got %0d want 3",
                                                       stat_searches); else passes++;
      checks++; if (stat_hits !== 16'd2) $display("FAIL stat_hits got %0d want 2", stat_hits);
      else passes++;
   endtask
`endif

   initial begin
      checks      = 0;
      passes      = 0;
      rst         = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      wr_next     = '0;
      start_valid = 1'b0;
      start_node  = '0;
      key         = '0;
      mode        = 1'b0;
      test_reset();
      load_lists();
      test_addr_match();
      test_data_match();
      test_miss();
      test_timeout();
      test_head_null();
      test_reset_mid_walk();
      test_back_to_back();
`ifdef LL_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
